panel_loader: RTL

- Synthesizable front-panel operator: accepts a stream of (address, data) words and turns each into timed Load-PC and Deposit switch/button sequences on the Front_Panel inputs.
- After the last word it loads the start PC, raises the RUN switch, and watches the RUN LED until the program halts.
- It is the hardware-side counterpart of the host word stream, so memory images load without a testbench driving the buttons.

---
 rtl/panel_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/panel_loader.sv
// Front-panel operator: turns (addr, data) words into timed Load-PC /
// Deposit button sequences, then starts the program and waits for halt.
module panel_loader #(
    parameter int SETUP_CYCLES   = 10,
    parameter int PRESS_CYCLES   = 10,
    parameter int RELEASE_CYCLES = 10,
    parameter bit AUTO_INC_SKIP  = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_addr,
    input  logic [11:0] in_data,
    input  logic        in_last,
    input  logic [11:0] start_pc,
    input  logic        run_led,
    output logic [12:0] sw,
    output logic        btnl,
    output logic        btnd,
    output logic        busy,
    output logic        done,
    output logic [12:0] words_loaded
);

    localparam int CW = 16;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_SETUP,
        LPC_PRESS,
        LPC_RELEASE,
        DATA_SETUP,
        DEP_PRESS,
        DEP_RELEASE,
        START_SETUP,
        START_PRESS,
        START_RELEASE,
        RUN_ARM,
        RUNNING,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [11:0]   addr_q;
    logic [11:0]   data_q;
    logic [11:0]   pc_q;
    logic [11:0]   prev_addr;
    logic          last_q;
    logic          prev_valid;
    logic          led_q;
    logic          accept;
    logic          skip_hit;
    logic          tick;
    logic          dep_done;
    logic [11:0]   sw_val_next;
    logic          btnl_next;
    logic          btnd_next;
    logic          run_next;

    // Counter reload value for each timed state (N-1, advance on 0)
    function automatic logic [CW-1:0] dur(input state_t s);
        case (s)
            ADDR_SETUP, DATA_SETUP, START_SETUP:
                dur = CW'(SETUP_CYCLES - 1);
            LPC_PRESS, DEP_PRESS, START_PRESS:
                dur = CW'(PRESS_CYCLES - 1);
            LPC_RELEASE, DEP_RELEASE, START_RELEASE:
                dur = CW'(RELEASE_CYCLES - 1);
            default:
                dur = '0;
        endcase
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE) && (state != DONE);
    assign accept   = in_valid && in_ready;
    assign tick     = (cnt == '0);
    assign dep_done = (state == DEP_RELEASE) && tick;
    assign skip_hit = AUTO_INC_SKIP && prev_valid
                      && (in_addr == prev_addr + 12'd1);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE:
                if (accept)
                    state_next = skip_hit ? DATA_SETUP : ADDR_SETUP;
            ADDR_SETUP:    if (tick) state_next = LPC_PRESS;
            LPC_PRESS:     if (tick) state_next = LPC_RELEASE;
            LPC_RELEASE:   if (tick) state_next = DATA_SETUP;
            DATA_SETUP:    if (tick) state_next = DEP_PRESS;
            DEP_PRESS:     if (tick) state_next = DEP_RELEASE;
            DEP_RELEASE:
                if (tick)
                    state_next = last_q ? START_SETUP : IDLE;
            START_SETUP:   if (tick) state_next = START_PRESS;
            START_PRESS:   if (tick) state_next = START_RELEASE;
            START_RELEASE: if (tick) state_next = RUN_ARM;
            RUN_ARM:       if (run_led) state_next = RUNNING;
            RUNNING:
                if (led_q && !run_led)
                    state_next = DONE;
            DONE:          state_next = DONE;
            default:       state_next = IDLE;
        endcase

        if (state_next != state)
            cnt_next = dur(state_next);
        else if (!tick)
            cnt_next = cnt - 1'b1;

        // Switch value only moves on entry to a setup state
        sw_val_next = sw[11:0];
        if (state_next != state) begin
            case (state_next)
                ADDR_SETUP:  sw_val_next = in_addr;
                DATA_SETUP:  sw_val_next = (state == IDLE) ? in_data : data_q;
                START_SETUP: sw_val_next = pc_q;
                default:     sw_val_next = sw[11:0];
            endcase
        end

        btnl_next = (state_next == LPC_PRESS) || (state_next == START_PRESS);
        btnd_next = (state_next == DEP_PRESS);
        run_next  = (state_next == RUN_ARM) || (state_next == RUNNING);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            sw           <= '0;
            btnl         <= 1'b0;
            btnd         <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            pc_q         <= '0;
            last_q       <= 1'b0;
            prev_addr    <= '0;
            prev_valid   <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sw    <= {run_next, sw_val_next};
            btnl  <= btnl_next;
            btnd  <= btnd_next;
            done  <= (state_next == DONE);
            led_q <= run_led;
            if (accept) begin
                addr_q <= in_addr;
                data_q <= in_data;
                last_q <= in_last;
                if (in_last)
                    pc_q <= start_pc;
            end
            if (dep_done) begin
                prev_addr  <= addr_q;
                prev_valid <= 1'b1;
                if (words_loaded != 13'd4096)
                    words_loaded <= words_loaded + 13'd1;
            end
        end
    end

endmodule
